// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand and result handshakes of the serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_adder_fa.sv
// Single combinational full-adder cell used by the serial datapath.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  // Sum and carry of one bit position.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end
endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one sum bit per clock, LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_adder_if.slave  bus
);
  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_cout;

  full_adder_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Handshake outputs decoded only from registered state.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = carry_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        // Counter holds on the last bit; it is only cleared by the next load.
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
        else                         cnt_d   = cnt_q + CW'(1);
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 (directed) and WIDTH=4 (exhaustive).
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst4 = 1'b1;
  logic stall4 = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   xfer4 = 0;
  int   acc4  = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Monitor: compare every result transfer against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst8 && if8.out_valid && if8.out_ready) begin
      if (q8.size() == 0) fail_now("unexpected_out8");
      else chk("result8", {23'd0, if8.cout, if8.sum}, {23'd0, q8.pop_front()});
    end
    if (!rst4 && if4.out_valid && if4.out_ready) begin
      xfer4++;
      if (q4.size() == 0) fail_now("unexpected_out4");
      else chk("result4", {27'd0, if4.cout, if4.sum}, {27'd0, q4.pop_front()});
    end
  end

  // Random result stalls on the 4-bit instance.
  initial forever begin
    @(posedge clk);
    #1 if4.out_ready = stall4 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [8:0] exp, input bit push);
    int n = 0;
    if8.a = a; if8.b = b; if8.cin = c; if8.in_valid = 1'b1;
    @(negedge clk);
    while (!if8.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!if8.in_ready) fail_now("accept_timeout8");
    else if (push) q8.push_back(exp);
    @(posedge clk);
    #1 if8.in_valid = 1'b0;
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q8.size() != 0) fail_now("drain_timeout8");
    @(posedge clk); #1;
  endtask

  task automatic add4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int n = 0;
    if4.a = a; if4.b = b; if4.cin = c; if4.in_valid = 1'b1;
    @(negedge clk);
    while (!if4.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!if4.in_ready) fail_now("accept_timeout4");
    else begin
      q4.push_back(5'({1'b0, a} + {1'b0, b} + {4'd0, c}));
      acc4++;
    end
    @(posedge clk);
    #1 if4.in_valid = 1'b0;
  endtask

  initial begin
    int n;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst8 = 1'b0; rst4 = 1'b0;
    chk("rst_in_ready8", 32'(if8.in_ready), 32'd1);
    chk("rst_out_valid8", 32'(if8.out_valid), 32'd0);
    chk("rst_sum8", 32'(if8.sum), 32'd0);
    chk("rst_cout8", 32'(if8.cout), 32'd0);
    chk("rst_in_ready4", 32'(if4.in_ready), 32'd1);
    chk("rst_out_valid4", 32'(if4.out_valid), 32'd0);

    // Latency: out_valid after E8, in_ready back after E9.
    add8(8'h35, 8'h4A, 1'b0, 9'h07F, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 7) chk("lat_ov_e7", 32'(if8.out_valid), 32'd0);
      if (k == 8) begin
        chk("lat_ov_e8", 32'(if8.out_valid), 32'd1);
        chk("lat_ir_e8", 32'(if8.in_ready), 32'd0);
      end
    end
    @(posedge clk); #1;
    chk("lat_ir_e9", 32'(if8.in_ready), 32'd1);
    chk("lat_ov_e9", 32'(if8.out_valid), 32'd0);

    // Operands offered during RUN are ignored.
    add8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
    if8.a = 8'hAA; if8.b = 8'h55; if8.cin = 1'b1; if8.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("run_in_ready", 32'(if8.in_ready), 32'd0);
    end
    if8.in_valid = 1'b0;
    drain8();

    add8(8'hFF, 8'h00, 1'b1, 9'h100, 1'b1);
    drain8();
    add8(8'h80, 8'h80, 1'b1, 9'h101, 1'b1);
    drain8();

    // Result held under backpressure.
    if8.out_ready = 1'b0;
    add8(8'h5A, 8'hC3, 1'b1, 9'h11E, 1'b1);
    n = 0;
    while (!if8.out_valid && n < 50) begin @(negedge clk); n++; end
    if (!if8.out_valid) fail_now("done_timeout8");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ov", 32'(if8.out_valid), 32'd1);
      chk("stall_res", {23'd0, if8.cout, if8.sum}, 32'h11E);
    end
    @(posedge clk); #1 if8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ir", 32'(if8.in_ready), 32'd1);
    chk("release_ov", 32'(if8.out_valid), 32'd0);

    // Reset on the edge that would process bit 3 aborts the add.
    add8(8'h12, 8'h34, 1'b0, 9'h046, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b1;
    @(posedge clk);
    #1 rst8 = 1'b0;
    chk("abort_ir", 32'(if8.in_ready), 32'd1);
    chk("abort_ov", 32'(if8.out_valid), 32'd0);
    chk("abort_sum", 32'(if8.sum), 32'd0);
    chk("abort_cout", 32'(if8.cout), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    add8(8'h12, 8'h34, 1'b0, 9'h046, 1'b1);
    drain8();

    // WIDTH=4 exhaustive with random result stalls.
    stall4 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      add4(4'((i >> 5) & 15), 4'((i >> 1) & 15), 1'(i & 1));
    end
    n = 0;
    while (q4.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (q4.size() != 0) fail_now("drain_timeout4");
    stall4 = 1'b0;
    repeat (10) @(posedge clk);
    chk("accepts4", 32'(acc4), 32'd512);
    chk("transfers4", 32'(xfer4), 32'd512);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
